// File: rtl/xor_pkg.sv
// Shared constants and width helpers for the xor_32 datapath.
package xor_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Bits needed to hold a count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/xor_32_popcount.sv
// Combinational popcount built as a recursive balanced adder tree.
module popcount
    import xor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = CNT_W'(bits);
        end else begin : g_split
            localparam int LO_W  = WIDTH / 2;
            localparam int HI_W  = WIDTH - LO_W;
            localparam int LO_CW = cnt_width(LO_W);
            localparam int HI_CW = cnt_width(HI_W);

            logic [LO_CW-1:0] lo_count;
            logic [HI_CW-1:0] hi_count;

            popcount #(.WIDTH(LO_W)) u_lo (
                .bits  (bits[LO_W-1:0]),
                .count (lo_count)
            );

            popcount #(.WIDTH(HI_W)) u_hi (
                .bits  (bits[WIDTH-1:LO_W]),
                .count (hi_count)
            );

            // Both halves are widened before the add so the carry into the top bit is kept.
            assign count = CNT_W'(lo_count) + CNT_W'(hi_count);
        end
    endgenerate

endmodule

// File: rtl/xor_32.sv
// Bitwise XOR with a zero-latency result and a registered result/Hamming-distance stage.
module xor_32
    import xor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] hd_q,
    output logic             zero_q
);

    logic [CNT_W-1:0] hd;

    assign y = a ^ b;

    popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_popcount (
        .bits  (y),
        .count (hd)
    );

    // Reset leaves zero_q=1 so the flag agrees with the cleared y_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_q       <= '0;
            hd_q      <= '0;
            zero_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_valid <= in_valid;
            if (in_valid) begin
                y_q    <= y;
                hd_q   <= hd;
                zero_q <= (y == '0);
            end
        end
    end

endmodule

// File: tb/tb_xor_32.sv
// Self-checking bench for xor_32: directed plan vectors, hold, back-to-back, async reset, random.
module tb_xor_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic [31:0] y;
    logic        out_valid;
    logic [31:0] y_q;
    logic [5:0]  hd_q;
    logic        zero_q;

    int n_cmp;
    int n_err;

    // Reference view of the registered stage.
    logic        exp_ov;
    logic [31:0] exp_y;
    logic [5:0]  exp_hd;
    logic        exp_zero;

    xor_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .y         (y),
        .out_valid (out_valid),
        .y_q       (y_q),
        .hd_q      (hd_q),
        .zero_q    (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ref_hd(input logic [31:0] x, input logic [31:0] z);
        return 6'($countones(x ^ z));
    endfunction

    task automatic model_reset();
        exp_ov   = 1'b0;
        exp_y    = 32'h0;
        exp_hd   = 6'd0;
        exp_zero = 1'b1;
    endtask

    // Apply inputs mid-cycle, then let combinational logic settle.
    task automatic drive(input logic [31:0] na, input logic [31:0] nb, input logic nv);
        @(negedge clk);
        a        = na;
        b        = nb;
        in_valid = nv;
        #1;
    endtask

    // Advance one rising edge, update the reference, and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (in_valid) begin
            exp_ov   = 1'b1;
            exp_y    = a ^ b;
            exp_hd   = ref_hd(a, b);
            exp_zero = (a == b);
        end else begin
            exp_ov = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = 32'h1234_5678;
        b = 32'h0F0F_F0F0;
        in_valid = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, y_q, hd_q, zero_q} !== {1'b0, 32'h0, 6'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got ov=%0b y_q=%h hd=%0d z=%0b, expected ov=0 y_q=0 hd=0 z=1",
                     out_valid, y_q, hd_q, zero_q);
        end
        n_cmp++;
        if (y !== 32'h1D3B_A688) begin
            n_err++;
            $display("FAIL y_in_reset: got %h, expected 1d3ba688", y);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h0000_FFFF, 32'hCCCC_CCCC};
        logic [31:0] vb [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_0000, 32'hAAAA_AAAA};
        logic [31:0] vy [5] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h6666_6666};
        int          vh [5] = '{0, 0, 32, 32, 16};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i], 1'b1);
            n_cmp++;
            if (y !== vy[i]) begin
                n_err++;
                $display("FAIL directed_y[%0d]: got %h, expected %h", i, y, vy[i]);
            end
            tick();
            n_cmp++;
            if ({out_valid, y_q, hd_q, zero_q} !== {1'b1, vy[i], 6'(vh[i]), (vh[i] == 0)}) begin
                n_err++;
                $display("FAIL directed_reg[%0d]: got ov=%0b y_q=%h hd=%0d z=%0b, expected ov=1 y_q=%h hd=%0d z=%0b",
                         i, out_valid, y_q, hd_q, zero_q, vy[i], vh[i], (vh[i] == 0));
            end
        end
    endtask

    task automatic test_async_reset();
        // Last capture was 0x66666666; assert reset between edges.
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({out_valid, y_q, hd_q, zero_q} !== {1'b0, 32'h0, 6'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got ov=%0b y_q=%h hd=%0d z=%0b, expected ov=0 y_q=0 hd=0 z=1",
                     out_valid, y_q, hd_q, zero_q);
        end
        n_cmp++;
        if (y !== 32'h6666_6666) begin
            n_err++;
            $display("FAIL async_reset_y: got %h, expected 66666666", y);
        end
        #1;
        rst_n = 1'b1;
        drive(32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1);
        tick();
        n_cmp++;
        if ({out_valid, y_q, hd_q, zero_q} !== {1'b1, 32'h0000_0001, 6'd1, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_capture: got ov=%0b y_q=%h hd=%0d z=%0b, expected ov=1 y_q=00000001 hd=1 z=0",
                     out_valid, y_q, hd_q, zero_q);
        end
    endtask

    task automatic test_hold();
        drive(32'hF0F0_0000, 32'h0000_0F0F, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] na;
            logic [31:0] nb;
            na = $urandom;
            nb = $urandom;
            drive(na, nb, 1'b0);
            n_cmp++;
            if (y !== (na ^ nb)) begin
                n_err++;
                $display("FAIL hold_y[%0d]: got %h, expected %h", i, y, na ^ nb);
            end
            tick();
            n_cmp++;
            if ({out_valid, y_q, hd_q, zero_q} !== {1'b0, 32'hF0F0_0F0F, 6'd16, 1'b0}) begin
                n_err++;
                $display("FAIL hold_reg[%0d]: got ov=%0b y_q=%h hd=%0d z=%0b, expected ov=0 y_q=f0f00f0f hd=16 z=0",
                         i, out_valid, y_q, hd_q, zero_q);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [3] = '{32'h8000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
        logic [31:0] bb [3] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            drive(ba[i], bb[i], 1'b1);
            tick();
            n_cmp++;
            if ({out_valid, y_q, hd_q, zero_q} !== {1'b1, exp_y, exp_hd, exp_zero}) begin
                n_err++;
                $display("FAIL b2b[%0d]: got ov=%0b y_q=%h hd=%0d z=%0b, expected ov=1 y_q=%h hd=%0d z=%0b",
                         i, out_valid, y_q, hd_q, zero_q, exp_y, exp_hd, exp_zero);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [31:0] na;
            logic [31:0] nb;
            na = $urandom;
            case ($urandom_range(3))
                0:       nb = na;
                1:       nb = na ^ (32'h1 << $urandom_range(31));
                default: nb = $urandom;
            endcase
            drive(na, nb, 1'($urandom_range(1)));
            n_cmp++;
            if (y !== (na ^ nb)) begin
                n_err++;
                $display("FAIL rand_y[%0d]: got %h, expected %h", i, y, na ^ nb);
            end
            tick();
            n_cmp++;
            if ({out_valid, y_q, hd_q, zero_q} !== {exp_ov, exp_y, exp_hd, exp_zero}) begin
                n_err++;
                $display("FAIL rand_reg[%0d]: got ov=%0b y_q=%h hd=%0d z=%0b, expected ov=%0b y_q=%h hd=%0d z=%0b",
                         i, out_valid, y_q, hd_q, zero_q, exp_ov, exp_y, exp_hd, exp_zero);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_async_reset();
        test_hold();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
